// File: rtl/uart_rx_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl_pkg
// Shared types and constants for the UART RX path controller.
//   rx_ctrl_state_t : controller FSM states (IDLE, HOLD, FLUSH)
//   IRQ_*           : bit positions inside the 3-bit sticky interrupt vector
//   DEFAULT_OSR     : default oversample ticks per bit
// -----------------------------------------------------------------------------
package uart_rx_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } rx_ctrl_state_t;

    localparam int IRQ_WMARK   = 0;
    localparam int IRQ_TO      = 1;
    localparam int IRQ_OVRN    = 2;
    localparam int IRQ_W       = 3;

    localparam int DEFAULT_OSR = 16;

endpackage

// File: rtl/uart_rx_ctrl_timer.sv
// -----------------------------------------------------------------------------
// rx_timeout_timer
// Character-timeout timer. A tick sub-counter divides osr_tick_i down to
// bit-times; a bit counter counts idle bit-times up to timeout_i, then holds.
//   clk_i       : system clock
//   reset_n_i   : asynchronous active-low reset
//   osr_tick_i  : oversample tick, one cycle wide
//   clear_i     : synchronous clear of both counters
//   timeout_i   : idle timeout in bit-times
//   expired_o   : one-cycle pulse on the tick that brings the count to timeout_i
// -----------------------------------------------------------------------------
module rx_timeout_timer #(
    parameter int OSR  = 16,
    parameter int TO_W = 8
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    input  logic            osr_tick_i,
    input  logic            clear_i,
    input  logic [TO_W-1:0] timeout_i,
    output logic            expired_o
);

    localparam int TICK_W = (OSR > 1) ? $clog2(OSR) : 1;

    logic [TICK_W-1:0] tick_cnt_q;
    logic [TO_W-1:0]   bit_cnt_q;
    logic [TO_W-1:0]   bit_cnt_inc;
    logic              tick_wrap;
    logic              saturated;

    assign tick_wrap   = (tick_cnt_q == TICK_W'(OSR - 1));
    assign bit_cnt_inc = bit_cnt_q + TO_W'(1);

    // Once the count has reached the programmed timeout (or the counter is
    // all-ones) the timer freezes, so an expiry fires exactly once per idle
    // period and cannot retrigger until something clears it.
    assign saturated = (bit_cnt_q == timeout_i) || (bit_cnt_q == '1);

    assign expired_o = !clear_i && osr_tick_i && tick_wrap && !saturated &&
                       (bit_cnt_inc == timeout_i);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else if (clear_i) begin
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else if (osr_tick_i && !saturated) begin
            if (tick_wrap) begin
                tick_cnt_q <= '0;
                bit_cnt_q  <= bit_cnt_inc;
            end else begin
                tick_cnt_q <= tick_cnt_q + TICK_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Sequences the UART RX path: gates the RX engine, drains the show-ahead RX
// FIFO into a valid/ready byte stream, flushes the FIFO on command and keeps
// sticky watermark / character-timeout / overrun interrupts.
//   clk_i, reset_n_i     : clock, asynchronous active-low reset
//   osr_tick_i           : oversample tick
//   ctrl_en_i            : RX enable request          -> rx_en_o
//   drain_en_i           : auto-drain FIFO to the stream port
//   flush_i              : pulse, discard FIFO contents and held byte
//   wmark_i, timeout_i   : watermark level / idle timeout (0 disables)
//   irq_ack_i            : write-1-to-clear {ovrn,timeout,wmark}
//   rx_busy_i, rx_ovrn_i : RX engine busy, FIFO sticky overrun
//   rx_lvl_i, rx_valid_i, rx_data_i : FIFO occupancy / head valid / head byte
//   rx_fifo_ren_o        : FIFO pop strobe
//   rx_clr_ovrn_o        : FIFO overrun clear strobe
//   m_data_o, m_valid_o, m_ready_i : byte stream
//   irq_o                : sticky {ovrn,timeout,wmark}
//   flush_busy_o         : flush in progress
// -----------------------------------------------------------------------------
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int OSR  = DEFAULT_OSR,
    parameter int TO_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             osr_tick_i,
    input  logic             ctrl_en_i,
    input  logic             drain_en_i,
    input  logic             flush_i,
    input  logic [4:0]       wmark_i,
    input  logic [TO_W-1:0]  timeout_i,
    input  logic [IRQ_W-1:0] irq_ack_i,
    input  logic             rx_busy_i,
    input  logic             rx_ovrn_i,
    input  logic [4:0]       rx_lvl_i,
    input  logic             rx_valid_i,
    input  logic [7:0]       rx_data_i,
    output logic             rx_en_o,
    output logic             rx_fifo_ren_o,
    output logic             rx_clr_ovrn_o,
    output logic [7:0]       m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [IRQ_W-1:0] irq_o,
    output logic             flush_busy_o
);

    rx_ctrl_state_t   state_q, state_d;
    logic             fifo_pop;
    logic             load_byte;
    logic [7:0]       m_data_q;
    logic             rx_en_q;
    logic [IRQ_W-1:0] irq_q;
    logic [IRQ_W-1:0] irq_set;
    logic [IRQ_W-1:0] irq_d;
    logic             clr_ovrn_q;
    logic             ovrn_prev_q;
    logic             to_clear;
    logic             to_expired;

    // Next-state and pop/load decisions. A flush request outranks every
    // other event outside FLUSH; inside FLUSH it is simply ignored. In HOLD
    // the byte is only released by a handshake, so dropping drain_en_i can
    // never lose a byte already presented on the stream port.
    always_comb begin
        state_d   = state_q;
        fifo_pop  = 1'b0;
        load_byte = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    state_d = FLUSH;
                end else if (drain_en_i && rx_valid_i) begin
                    fifo_pop  = 1'b1;
                    load_byte = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (flush_i) begin
                    state_d = FLUSH;
                end else if (m_ready_i) begin
                    if (drain_en_i && rx_valid_i) begin
                        fifo_pop  = 1'b1;
                        load_byte = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FLUSH: begin
                fifo_pop = rx_valid_i;
                if (!rx_valid_i && !rx_busy_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The timeout only runs while bytes sit in the FIFO with the line idle
    // and nobody reading; any of those conditions restarts it.
    assign to_clear = fifo_pop || rx_busy_i || (rx_lvl_i == '0) || (timeout_i == '0);

    rx_timeout_timer #(
        .OSR  (OSR),
        .TO_W (TO_W)
    ) u_timer (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .osr_tick_i (osr_tick_i),
        .clear_i    (to_clear),
        .timeout_i  (timeout_i),
        .expired_o  (to_expired)
    );

    // Sticky interrupts: a set event in the same cycle as its ack wins.
    always_comb begin
        irq_set            = '0;
        irq_set[IRQ_WMARK] = (wmark_i != '0) && (rx_lvl_i >= wmark_i);
        irq_set[IRQ_TO]    = to_expired;
        irq_set[IRQ_OVRN]  = rx_ovrn_i && !ovrn_prev_q;
        irq_d              = irq_set | (irq_q & ~irq_ack_i);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            m_data_q    <= '0;
            rx_en_q     <= 1'b0;
            irq_q       <= '0;
            clr_ovrn_q  <= 1'b0;
            ovrn_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            if (load_byte) begin
                m_data_q <= rx_data_i;
            end
            rx_en_q     <= ctrl_en_i && (state_q != FLUSH);
            irq_q       <= irq_d;
            clr_ovrn_q  <= irq_ack_i[IRQ_OVRN];
            ovrn_prev_q <= rx_ovrn_i;
        end
    end

    // The pop strobe is combinational, so it is forced low while reset is
    // asserted to keep the FIFO untouched during reset.
    assign rx_fifo_ren_o = fifo_pop && reset_n_i;
    assign rx_en_o       = rx_en_q;
    assign rx_clr_ovrn_o = clr_ovrn_q;
    assign m_data_o      = m_data_q;
    assign m_valid_o     = (state_q == HOLD);
    assign irq_o         = irq_q;
    assign flush_busy_o  = (state_q == FLUSH);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Directed bench for uart_rx_ctrl. A small array-based FIFO model plays the
// RX FIFO: it pops one entry after every clock edge at which the DUT strobed
// rx_fifo_ren_o, so the DUT sees the pop reflected on the following cycle.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    localparam int OSR  = 16;
    localparam int TO_W = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            osr_tick;
    logic            ctrl_en;
    logic            drain_en;
    logic            flush;
    logic [4:0]      wmark;
    logic [TO_W-1:0] timeout;
    logic [2:0]      irq_ack;
    logic            rx_busy;
    logic            rx_ovrn;
    logic [4:0]      rx_lvl;
    logic            rx_valid;
    logic [7:0]      rx_data;
    logic            rx_en;
    logic            rx_fifo_ren;
    logic            rx_clr_ovrn;
    logic [7:0]      m_data;
    logic            m_valid;
    logic            m_ready;
    logic [2:0]      irq;
    logic            flush_busy;

    logic [7:0] fifo_mem [0:31];
    int         fifo_head;
    int         fifo_cnt;
    logic       ren_seen;
    int         pop_count;
    int         check_count;
    int         fail_count;
    int         hold_err;

    always #5 clk = ~clk;

    assign rx_valid = (fifo_cnt != 0);
    assign rx_lvl   = 5'(fifo_cnt);
    assign rx_data  = fifo_mem[fifo_head];

    // The pop strobe is stable mid-cycle; capture it for the following edge.
    always @(negedge clk) ren_seen = rx_fifo_ren;

    uart_rx_ctrl #(
        .OSR  (OSR),
        .TO_W (TO_W)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .osr_tick_i    (osr_tick),
        .ctrl_en_i     (ctrl_en),
        .drain_en_i    (drain_en),
        .flush_i       (flush),
        .wmark_i       (wmark),
        .timeout_i     (timeout),
        .irq_ack_i     (irq_ack),
        .rx_busy_i     (rx_busy),
        .rx_ovrn_i     (rx_ovrn),
        .rx_lvl_i      (rx_lvl),
        .rx_valid_i    (rx_valid),
        .rx_data_i     (rx_data),
        .rx_en_o       (rx_en),
        .rx_fifo_ren_o (rx_fifo_ren),
        .rx_clr_ovrn_o (rx_clr_ovrn),
        .m_data_o      (m_data),
        .m_valid_o     (m_valid),
        .m_ready_i     (m_ready),
        .irq_o         (irq),
        .flush_busy_o  (flush_busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic pushByte(input logic [7:0] b);
        fifo_mem[(fifo_head + fifo_cnt) % 32] = b;
        fifo_cnt++;
    endtask

    // Advance n clock edges, applying the FIFO pops the DUT requested.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (ren_seen && fifo_cnt > 0) begin
                fifo_head = (fifo_head + 1) % 32;
                fifo_cnt--;
                pop_count++;
            end
        end
    endtask

    initial begin
        check_count = 0;
        fail_count  = 0;
        pop_count   = 0;
        fifo_head   = 0;
        fifo_cnt    = 0;
        ren_seen    = 1'b0;
        for (int i = 0; i < 32; i++) fifo_mem[i] = 8'h00;
        reset_n  = 1'b0;
        osr_tick = 1'b0;
        ctrl_en  = 1'b0;
        drain_en = 1'b0;
        flush    = 1'b0;
        wmark    = 5'd0;
        timeout  = '0;
        irq_ack  = 3'b000;
        rx_busy  = 1'b0;
        rx_ovrn  = 1'b0;
        m_ready  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs",
                    {rx_en, rx_fifo_ren, rx_clr_ovrn, m_data, m_valid, irq, flush_busy}, 0);
        reset_n = 1'b1;
        ctrl_en = 1'b1;
        applyStimulus(1);
        checkOutput("rx_en_on", rx_en, 1);

        // 1: stream three queued bytes back to back
        $display("[TB] drain three bytes with ready high");
        pushByte(8'h11); pushByte(8'h22); pushByte(8'h33);
        drain_en  = 1'b1;
        m_ready   = 1'b1;
        pop_count = 0;
        applyStimulus(1);
        checkOutput("t1_valid0", m_valid, 1);
        checkOutput("t1_data0", m_data, 8'h11);
        applyStimulus(1);
        checkOutput("t1_data1", m_data, 8'h22);
        applyStimulus(1);
        checkOutput("t1_data2", m_data, 8'h33);
        checkOutput("t1_valid2", m_valid, 1);
        applyStimulus(1);
        checkOutput("t1_valid_end", m_valid, 0);
        checkOutput("t1_pops", pop_count, 3);

        // 2: backpressure holds the byte stable
        $display("[TB] backpressure with two bytes queued");
        m_ready   = 1'b0;
        pop_count = 0;
        hold_err  = 0;
        pushByte(8'h11); pushByte(8'h22);
        applyStimulus(1);
        checkOutput("t2_data0", m_data, 8'h11);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1);
            if (m_data !== 8'h11 || m_valid !== 1'b1) hold_err++;
        end
        checkOutput("t2_hold_stable", hold_err, 0);
        checkOutput("t2_single_pop", pop_count, 1);
        m_ready = 1'b1;
        applyStimulus(1);
        checkOutput("t2_data1", m_data, 8'h22);
        checkOutput("t2_valid1", m_valid, 1);
        applyStimulus(1);
        checkOutput("t2_valid_end", m_valid, 0);
        checkOutput("t2_pops", pop_count, 2);
        drain_en = 1'b0;

        // 3: watermark
        $display("[TB] watermark at level 4");
        wmark = 5'd4;
        for (int i = 0; i < 4; i++) begin
            pushByte(8'(8'h40 + i));
            applyStimulus(1);
            if (i == 2) checkOutput("t3_below", irq[0], 0);
        end
        checkOutput("t3_set", irq[0], 1);
        irq_ack = 3'b001;
        applyStimulus(1);
        irq_ack = 3'b000;
        checkOutput("t3_ack_held", irq[0], 1);
        drain_en = 1'b1;
        m_ready  = 1'b0;
        applyStimulus(1);
        drain_en = 1'b0;
        applyStimulus(1);
        checkOutput("t3_lvl3", fifo_cnt, 3);
        irq_ack = 3'b001;
        applyStimulus(1);
        irq_ack = 3'b000;
        checkOutput("t3_cleared", irq[0], 0);
        m_ready = 1'b1;
        applyStimulus(1);
        checkOutput("t3_idle", m_valid, 0);
        drain_en = 1'b1;
        applyStimulus(1);
        drain_en = 1'b0;
        applyStimulus(1);
        checkOutput("t3_lvl2", fifo_cnt, 2);
        wmark = 5'd0;

        // 4: character timeout, 4 bit-times of 16 ticks
        $display("[TB] character timeout");
        timeout = 8'd4;
        applyStimulus(1);
        osr_tick = 1'b1;
        applyStimulus(40);
        osr_tick = 1'b0;
        checkOutput("t4_before_pop", irq[1], 0);
        drain_en = 1'b1;
        applyStimulus(1);
        drain_en = 1'b0;
        applyStimulus(1);
        checkOutput("t4_lvl1", fifo_cnt, 1);
        osr_tick = 1'b1;
        applyStimulus(63);
        checkOutput("t4_restart", irq[1], 0);
        applyStimulus(1);
        checkOutput("t4_expired", irq[1], 1);
        osr_tick = 1'b0;
        irq_ack = 3'b010;
        applyStimulus(1);
        irq_ack = 3'b000;
        checkOutput("t4_acked", irq[1], 0);
        osr_tick = 1'b1;
        applyStimulus(32);
        osr_tick = 1'b0;
        checkOutput("t4_saturated", irq[1], 0);
        timeout = '0;

        // 5: overrun
        $display("[TB] overrun interrupt");
        rx_ovrn = 1'b1;
        applyStimulus(1);
        checkOutput("t5_set", irq[2], 1);
        applyStimulus(1);
        checkOutput("t5_sticky", irq[2], 1);
        checkOutput("t5_no_clr", rx_clr_ovrn, 0);
        irq_ack = 3'b100;
        applyStimulus(1);
        irq_ack = 3'b000;
        checkOutput("t5_cleared", irq[2], 0);
        checkOutput("t5_clr_pulse", rx_clr_ovrn, 1);
        applyStimulus(1);
        checkOutput("t5_clr_end", rx_clr_ovrn, 0);
        checkOutput("t5_no_retrigger", irq[2], 0);
        rx_ovrn = 1'b0;

        // 6: flush from HOLD with five bytes left
        $display("[TB] flush from HOLD");
        for (int i = 0; i < 5; i++) pushByte(8'(8'h60 + i));
        drain_en = 1'b1;
        m_ready  = 1'b0;
        applyStimulus(1);
        checkOutput("t6_hold", m_valid, 1);
        checkOutput("t6_lvl5", fifo_cnt, 5);
        pop_count = 0;
        flush = 1'b1;
        applyStimulus(1);
        flush = 1'b0;
        checkOutput("t6_valid_drop", m_valid, 0);
        checkOutput("t6_busy", flush_busy, 1);
        applyStimulus(2);
        checkOutput("t6_rx_en_off", rx_en, 0);
        applyStimulus(3);
        checkOutput("t6_pops", pop_count, 5);
        checkOutput("t6_busy_tail", flush_busy, 1);
        applyStimulus(1);
        checkOutput("t6_busy_done", flush_busy, 0);
        applyStimulus(1);
        checkOutput("t6_rx_en_back", rx_en, 1);

        // Async reset in the middle of a flush held open by rx_busy
        rx_busy = 1'b1;
        flush   = 1'b1;
        pushByte(8'h71); pushByte(8'h72); pushByte(8'h73);
        applyStimulus(1);
        flush = 1'b0;
        applyStimulus(4);
        checkOutput("t6_flush_held", flush_busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t6_async_reset",
                    {rx_en, rx_fifo_ren, rx_clr_ovrn, m_data, m_valid, irq, flush_busy}, 0);
        rx_busy  = 1'b0;
        drain_en = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        applyStimulus(1);
        checkOutput("t6_after_reset", flush_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 check_count, fail_count);
        $finish;
    end

endmodule
